// File: rtl/pulse_blinker_pkg.sv
`default_nettype none
// ============================================================================
// Module : pulse_blinker_pkg
// Brief  : Shared state encodings and constant helpers for the LED blinker.
// Rev    : 1.0  initial release
// ============================================================================
package pulse_blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } blink_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module : phase_timer
// Brief  : Loadable down-counter that stops at zero and flags it.
// Rev    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Holds at zero so an idle timer never wraps.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_blinker.sv
`default_nettype none
// ============================================================================
// Module : pulse_blinker
// Brief  : Turns single-cycle event pulses into queued, timed LED blinks.
// Rev    : 1.0  initial release
// ============================================================================
module pulse_blinker
    import pulse_blinker_pkg::*;
#(
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int PEND_W     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [TW-1:0] C_ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] C_OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic          C_LED_LIT  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic          C_LED_DARK = ~C_LED_LIT;

    blink_state_t      r_state;
    blink_state_t      w_state_next;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_next;
    logic              r_overflow;
    logic              w_overflow_set;
    logic              r_led;
    logic              r_busy;
    logic              w_consume;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_timer_zero;

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (clear),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_timer_zero)
    );

    // Next-state logic; a consume always coincides with entering ON.
    always_comb begin
        w_state_next = r_state;
        w_consume    = 1'b0;
        w_load       = 1'b0;
        w_load_val   = C_ON_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_state_next = ST_ON;
                    w_consume    = 1'b1;
                    w_load       = 1'b1;
                end
            end
            ST_ON: begin
                if (w_timer_zero) begin
                    w_state_next = ST_OFF;
                    w_load       = 1'b1;
                    w_load_val   = C_OFF_LOAD;
                end
            end
            ST_OFF: begin
                if (w_timer_zero) begin
                    if (r_pend != '0) begin
                        w_state_next = ST_ON;
                        w_consume    = 1'b1;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_pend_next    = r_pend;
        w_overflow_set = 1'b0;
        if (pulse_in && !w_consume) begin
            if (&r_pend) begin
                w_overflow_set = 1'b1;
            end else begin
                w_pend_next = r_pend + 1'b1;
            end
        end else if (w_consume && !pulse_in) begin
            w_pend_next = r_pend - 1'b1;
        end
    end

    // Outputs are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_overflow <= 1'b0;
            r_led      <= C_LED_DARK;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pend     <= w_pend_next;
            r_overflow <= r_overflow | w_overflow_set;
            r_led      <= (w_state_next == ST_ON) ? C_LED_LIT : C_LED_DARK;
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign led_out    = r_led;
    assign busy       = r_busy;
    assign pend_count = r_pend;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pulse_blinker.sv
`default_nettype none
// ============================================================================
// Module : tb_pulse_blinker
// Brief  : Scoreboard bench for pulse_blinker (ON=4, OFF=2, PEND_W=2, active-low).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pulse_blinker;

    localparam int C_ON  = 4;
    localparam int C_OFF = 2;
    localparam int C_MAX = 3;

    logic       clk;
    logic       reset;
    logic       pulse_in;
    logic       clear;
    logic       led_out;
    logic       busy;
    logic [1:0] pend_count;
    logic       overflow;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    exp_t  sb[$];
    int    total;
    int    bad;
    string g_tst;

    // Reference model: phase 0 idle, 1 lit, 2 dark; m_left = cycles left in phase.
    int m_phase;
    int m_left;
    int m_pend;
    bit m_ovf;

    pulse_blinker #(
        .ON_CYCLES  (C_ON),
        .OFF_CYCLES (C_OFF),
        .PEND_W     (2),
        .ACTIVE_LOW (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .clear      (clear),
        .led_out    (led_out),
        .busy       (busy),
        .pend_count (pend_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s: got=%0h expected=%0h", g_tst, tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic p, input logic c, input logic r);
        bit take;
        take = 1'b0;
        if (r || c) begin
            m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (m_pend > 0) begin
                    take = 1'b1; m_phase = 1; m_left = C_ON;
                end
            end else if (m_phase == 1) begin
                if (m_left == 1) begin
                    m_phase = 2; m_left = C_OFF;
                end else begin
                    m_left--;
                end
            end else begin
                if (m_left == 1) begin
                    if (m_pend > 0) begin
                        take = 1'b1; m_phase = 1; m_left = C_ON;
                    end else begin
                        m_phase = 0; m_left = 0;
                    end
                end else begin
                    m_left--;
                end
            end
            if (p && !take) begin
                if (m_pend == C_MAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (take && !p) begin
                m_pend--;
            end
        end
    endtask

    task automatic step(input logic p, input logic c, input logic r);
        exp_t e;
        pulse_in = p;
        clear    = c;
        reset    = r;
        model_edge(p, c, r);
        e.led  = (m_phase == 1) ? 1'b0 : 1'b1;
        e.busy = (m_phase != 0);
        e.pend = 2'(m_pend);
        e.ovf  = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("led",  {31'd0, led_out},    {31'd0, e.led});
        chk("busy", {31'd0, busy},       {31'd0, e.busy});
        chk("pend", {30'd0, pend_count}, {30'd0, e.pend});
        chk("ovf",  {31'd0, overflow},   {31'd0, e.ovf});
        pulse_in = 1'b0;
        clear    = 1'b0;
        reset    = 1'b0;
    endtask

    // Idles until the DUT reports not busy, counting lit and dark-busy cycles.
    task automatic run_idle(output int lit, output int dark);
        bit done;
        lit  = 0;
        dark = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (led_out == 1'b0) lit++;
            else if (busy) dark++;
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lit;
        int dark;
        bit hit;
        total = 0; bad = 0;
        m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
        pulse_in = 1'b0; clear = 1'b0; reset = 1'b1;

        g_tst = "reset";
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_led", {31'd0, led_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        g_tst = "single";
        step(1'b1, 1'b0, 1'b0);
        chk("pend_after_pulse", {30'd0, pend_count}, 32'd1);
        run_idle(lit, dark);
        chk("lit_cycles", lit, C_ON);
        chk("dark_cycles", dark, C_OFF);

        g_tst = "triple";
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_idle(lit, dark);
        chk("lit_cycles", lit + 2, 3 * C_ON);
        chk("dark_cycles", dark, 3 * C_OFF);

        g_tst = "saturate";
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("pend_seq", {30'd0, pend_count}, (i < 3) ? i + 1 : 3);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        run_idle(lit, dark);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        g_tst = "coincide";
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_phase == 2 && m_left == 1) hit = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        chk("reach_off_end", {31'd0, hit}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("pend_hold", {30'd0, pend_count}, 32'd3);
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        chk("relit", {31'd0, led_out}, 32'd0);
        run_idle(lit, dark);

        g_tst = "clear";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("pend_before", {30'd0, pend_count}, 32'd2);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_led", {31'd0, led_out}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_pend", {30'd0, pend_count}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        run_idle(lit, dark);
        chk("after_lit", lit, C_ON);

        g_tst = "reset_off";
        step(1'b1, 1'b0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (m_phase == 2) hit = 1'b1;
        end
        chk("reach_off", {31'd0, hit}, 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_led", {31'd0, led_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pend", {30'd0, pend_count}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("no_start", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
